// File: rtl/and2_pkg.sv
// Shared constants for the and2 block: op encoding, default width, counter width.
// The optional OR operation is enabled by defining AND2_OR_OP_EN.
package and2_pkg;

  localparam logic OP_AND        = 1'b0;
  localparam logic OP_OR         = 1'b1;
  localparam int   DEFAULT_WIDTH = 1;
  localparam int   COUNT_W       = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == {COUNT_W{1'b1}}) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/and2_core.sv
// Combinational bitwise operation for and2. AND always; OR selectable by op
// only when AND2_OR_OP_EN is defined, otherwise op is ignored.
module and2_core
  import and2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic             op,
  output logic [WIDTH-1:0] result
);

`ifdef AND2_OR_OP_EN
  always_comb begin
    result = i1 & i2;
    if (op == OP_OR) result = i1 | i2;
  end
`else
  logic w_op_unused;
  assign w_op_unused = op;
  assign result      = i1 & i2;
`endif

endmodule

// File: rtl/and2.sv
// Single-entry registered and2 stage with valid/ready handshake and a saturating
// delivered-result counter. AND2_OR_OP_EN enables op-selected OR in and2_core.
//
// Handshake: a transfer happens on an edge where valid && ready on that side.
// in_ready = !out_valid || out_ready, so a held result that is being consumed
// frees the slot in the same cycle (one result per cycle when streaming).
module and2
  import and2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   i1,
  input  logic [WIDTH-1:0]   i2,
  input  logic               op,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   o,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COUNT_W-1:0] count
);

  logic [WIDTH-1:0]   r_o;
  logic               r_out_valid;
  logic [COUNT_W-1:0] r_count;
  logic [WIDTH-1:0]   w_result;
  logic               w_in_fire;
  logic               w_out_fire;

  and2_core #(.WIDTH(WIDTH)) u_core (
    .i1     (i1),
    .i2     (i2),
    .op     (op),
    .result (w_result)
  );

  // Forced high during reset so ready reads 1 even while a result is held.
  assign in_ready   = !rst_n || !r_out_valid || out_ready;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_o         <= '0;
      r_out_valid <= 1'b0;
      r_count     <= '0;
    end else begin
      if (w_in_fire) begin
        r_o         <= w_result;
        r_out_valid <= 1'b1;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
      if (w_out_fire) r_count <= sat_inc(r_count);
    end
  end

  assign o         = r_o;
  assign out_valid = r_out_valid;
  assign count     = r_count;

endmodule

// File: tb/tb_and2.sv
// Bench for and2: truth table on a 1-bit instance, directed and random
// handshake sequences on an 8-bit instance against a queue-based model.
module tb_and2;
  import and2_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [7:0]  i1_8, i2_8, o_8;
  logic        op_8, in_valid_8, in_ready_8, out_valid_8, out_ready_8;
  logic [15:0] count_8;

  logic        i1_1, i2_1, o_1;
  logic        op_1, in_valid_1, in_ready_1, out_valid_1, out_ready_1;
  logic [15:0] count_1;

  and2 #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .i1(i1_8), .i2(i2_8), .op(op_8),
    .in_valid(in_valid_8), .in_ready(in_ready_8), .o(o_8),
    .out_valid(out_valid_8), .out_ready(out_ready_8), .count(count_8)
  );

  and2 #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i1(i1_1), .i2(i2_1), .op(op_1),
    .in_valid(in_valid_1), .in_ready(in_ready_1), .o(o_1),
    .out_valid(out_valid_1), .out_ready(out_ready_1), .count(count_1)
  );

  int checks   = 0;
  int failures = 0;

  // Reference: a one-deep buffer of pending results plus a delivered count.
  logic [7:0]  exp_q[$];
  int unsigned exp_count;

  typedef struct {
    logic a;
    logic b;
    logic op;
    logic exp;
  } tt_vec_t;
  tt_vec_t tt[8];

  function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                        input logic opv);
`ifdef AND2_OR_OP_EN
    return opv ? (a | b) : (a & b);
`else
    return a & b;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One cycle on the 8-bit instance: drive, check pre-edge outputs, clock, update model.
  task automatic step8(input logic iv, input logic [7:0] a, input logic [7:0] b,
                       input logic opv, input logic ordy, input string tag);
    bit out_fire, in_fire;
    in_valid_8 = iv; i1_8 = a; i2_8 = b; op_8 = opv; out_ready_8 = ordy;
    #1;
    check({tag, "_in_ready"}, in_ready_8, (exp_q.size() == 0) || ordy);
    check({tag, "_out_valid"}, out_valid_8, exp_q.size() != 0);
    check({tag, "_count"}, count_8, exp_count);
    if (exp_q.size() != 0) check({tag, "_o"}, o_8, exp_q[0]);
    out_fire = (exp_q.size() != 0) && ordy;
    in_fire  = iv && ((exp_q.size() == 0) || ordy);
    @(posedge clk); #1;
    if (out_fire) begin
      void'(exp_q.pop_front());
      if (exp_count < 65535) exp_count++;
    end
    if (in_fire) exp_q.push_back(ref_op(a, b, opv));
  endtask

  task automatic reset_all(input string tag);
    rst_n = 1'b0;
    in_valid_8 = 1'b0; out_ready_8 = 1'b0;
    in_valid_1 = 1'b0; out_ready_1 = 1'b0;
    #1;
    check({tag, "_rst_in_ready8"}, in_ready_8, 1);
    check({tag, "_rst_in_ready1"}, in_ready_1, 1);
    @(posedge clk); #1;
    check({tag, "_rst_o8"}, o_8, 0);
    check({tag, "_rst_ov8"}, out_valid_8, 0);
    check({tag, "_rst_cnt8"}, count_8, 0);
    check({tag, "_rst_o1"}, o_1, 0);
    check({tag, "_rst_ov1"}, out_valid_1, 0);
    check({tag, "_rst_cnt1"}, count_1, 0);
    check({tag, "_rst_in_ready8_held"}, in_ready_8, 1);
    rst_n = 1'b1;
    exp_q.delete();
    exp_count = 0;
  endtask

  initial begin
    tt[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tt[1] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tt[2] = '{1'b1, 1'b0, 1'b0, 1'b0};
    tt[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
`ifdef AND2_OR_OP_EN
    tt[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tt[5] = '{1'b0, 1'b1, 1'b1, 1'b1};
    tt[6] = '{1'b1, 1'b0, 1'b1, 1'b1};
    tt[7] = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
    tt[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tt[5] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tt[6] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tt[7] = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    i1_8 = '0; i2_8 = '0; op_8 = 1'b0;
    i1_1 = 1'b0; i2_1 = 1'b0; op_1 = 1'b0;
    exp_count = 0;

    reset_all("init");

    // Truth tables on the 1-bit instance, AND group then op=1 group.
    for (int g = 0; g < 2; g++) begin
      for (int r = 0; r < 4; r++) begin
        i1_1 = tt[g*4+r].a; i2_1 = tt[g*4+r].b; op_1 = tt[g*4+r].op;
        in_valid_1 = 1'b1; out_ready_1 = 1'b1;
        @(posedge clk); #1;
        check($sformatf("tt_o_%0d", g*4+r), o_1, tt[g*4+r].exp);
        check($sformatf("tt_ov_%0d", g*4+r), out_valid_1, 1);
        check($sformatf("tt_ready_%0d", g*4+r), in_ready_1, 1);
      end
      in_valid_1 = 1'b0;
      @(posedge clk); #1;
      check($sformatf("tt_count_g%0d", g), count_1, 4 * (g + 1));
      check($sformatf("tt_drain_ov_g%0d", g), out_valid_1, 0);
    end
    out_ready_1 = 1'b0;

    // Backpressure: result held while the consumer stalls, idle inputs carry x.
    reset_all("bp");
    step8(1'b1, 8'hF0, 8'h3C, 1'b0, 1'b0, "bp_load");
    for (int k = 0; k < 3; k++) step8(1'b0, 8'hxx, 8'hxx, 1'b0, 1'b0, "bp_hold");
    check("bp_o_direct", o_8, 8'h30);
    check("bp_in_ready_direct", in_ready_8, 0);
    check("bp_count_direct", count_8, 0);
    step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, "bp_release");
    check("bp_count_after", count_8, 1);
    check("bp_ov_after", out_valid_8, 0);

    // Streaming: ten back-to-back transfers then drain.
    reset_all("stream");
    for (int k = 0; k < 10; k++)
      step8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1, "stream");
    step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, "stream_drain");
    check("stream_count", count_8, 10);

    // Reset while a result is held discards it.
    reset_all("midrst_pre");
    step8(1'b1, 8'hA5, 8'hFF, 1'b0, 1'b0, "midrst_load");
    check("midrst_ov_before", out_valid_8, 1);
    reset_all("midrst");

    // Random handshake traffic.
    for (int k = 0; k < 400; k++)
      step8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), "rand");

    // Saturation: continuous flow, first edge only loads.
    reset_all("sat");
    i1_8 = 8'hFF; i2_8 = 8'h0F; op_8 = 1'b0;
    in_valid_8 = 1'b1; out_ready_8 = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    check("sat_fffe", count_8, 16'hFFFE);
    @(posedge clk); #1;
    check("sat_ffff", count_8, 16'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    check("sat_hold", count_8, 16'hFFFF);
    check("sat_o", o_8, 8'h0F);
    in_valid_8 = 1'b0; out_ready_8 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
